// File: rtl/pong_sync_timer_pkg.sv
// Shared timing constants and count type for the Pong video timing base.
package pong_timing_pkg;

    localparam int unsigned CNT_W = 9;
    typedef logic [CNT_W-1:0] count9_t;

    localparam int unsigned DEF_H_TOTAL     = 455;
    localparam int unsigned DEF_V_TOTAL     = 262;
    localparam int unsigned DEF_H_BLANK_END = 80;
    localparam int unsigned DEF_HSYNC_START = 32;
    localparam int unsigned DEF_HSYNC_END   = 64;
    localparam int unsigned DEF_V_BLANK_END = 16;
    localparam int unsigned DEF_VSYNC_START = 4;
    localparam int unsigned DEF_VSYNC_END   = 8;

endpackage

// File: rtl/pong_sync_timer_if.sv
// Timing bus: pixel enable in, counts and strobes out to the downstream game blocks.
interface pong_sync_timer_if;
    import pong_timing_pkg::*;

    logic    ce;
    count9_t hcnt;
    count9_t vcnt;
    logic    hreset;
    logic    vreset;
    logic    hblank;
    logic    vblank;
    logic    hsync_n;
    logic    vsync_n;
    logic    line_tick;
    logic    frame_tick;

    modport master (
        input  ce,
        output hcnt, vcnt, hreset, vreset, hblank, vblank,
               hsync_n, vsync_n, line_tick, frame_tick
    );

    modport slave (
        output ce,
        input  hcnt, vcnt, hreset, vreset, hblank, vblank,
               hsync_n, vsync_n, line_tick, frame_tick
    );
endinterface

// File: rtl/pong_tc_counter.sv
// Modulo-N counter with enable; exposes its next-state count so callers can
// register decodes aligned with the count, plus a registered terminal-count flag.
module pong_tc_counter
    import pong_timing_pkg::*;
#(
    parameter int unsigned N = DEF_H_TOTAL
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en_i,
    output count9_t cnt_o,
    output count9_t cnt_d_o_c,
    output logic    tc_o,
    output logic    wrap_o_c
);
    localparam count9_t LAST = count9_t'(N - 1);

    count9_t cnt_q, cnt_d;
    logic    tc_q, tc_d;

    always_comb begin
        wrap_o_c = en_i && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o_c ? '0 : cnt_q + count9_t'(1);
        end
        tc_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_d_o_c = cnt_d;
    assign tc_o      = tc_q;
endmodule

// File: rtl/pong_sync_timer.sv
// Pong video timing base: cascaded horizontal/vertical counters with blank,
// sync and tick strobes registered from the next-state counts (zero skew to the counts).
module pong_sync_timer
    import pong_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned H_BLANK_END = DEF_H_BLANK_END,
    parameter int unsigned HSYNC_START = DEF_HSYNC_START,
    parameter int unsigned HSYNC_END   = DEF_HSYNC_END,
    parameter int unsigned V_BLANK_END = DEF_V_BLANK_END,
    parameter int unsigned VSYNC_START = DEF_VSYNC_START,
    parameter int unsigned VSYNC_END   = DEF_VSYNC_END
) (
    input logic               clk,
    input logic               rst_n,
    pong_sync_timer_if.master bus
);
    if (H_TOTAL > 512 || V_TOTAL > 512 || H_TOTAL < 2 || V_TOTAL < 2 ||
        !(HSYNC_START < HSYNC_END && HSYNC_END <= H_BLANK_END) ||
        !(VSYNC_START < VSYNC_END && VSYNC_END <= V_BLANK_END)) begin : g_param_chk
        $error("pong_sync_timer: illegal timing parameters");
    end

    count9_t h_q, h_d, v_q, v_d;
    logic    h_tc, v_tc;
    logic    h_wrap_c, v_wrap_c, v_en_c;

    // The vertical counter advances only on the horizontal wrap, same clock.
    assign v_en_c = bus.ce & h_wrap_c;

    pong_tc_counter #(.N(H_TOTAL)) u_hcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (bus.ce),
        .cnt_o     (h_q),
        .cnt_d_o_c (h_d),
        .tc_o      (h_tc),
        .wrap_o_c  (h_wrap_c)
    );

    pong_tc_counter #(.N(V_TOTAL)) u_vcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (v_en_c),
        .cnt_o     (v_q),
        .cnt_d_o_c (v_d),
        .tc_o      (v_tc),
        .wrap_o_c  (v_wrap_c)
    );

    logic hblank_q, hblank_d, vblank_q, vblank_d;
    logic hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;

    always_comb begin
        hblank_d     = (h_d < count9_t'(H_BLANK_END));
        hsync_n_d    = !((h_d >= count9_t'(HSYNC_START)) && (h_d < count9_t'(HSYNC_END)));
        vblank_d     = (v_d < count9_t'(V_BLANK_END));
        vsync_n_d    = !((v_d >= count9_t'(VSYNC_START)) && (v_d < count9_t'(VSYNC_END)));
        line_tick_d  = h_wrap_c;
        frame_tick_d = v_wrap_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hblank_q     <= 1'b1;
            vblank_q     <= 1'b1;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.hcnt       = h_q;
    assign bus.vcnt       = v_q;
    assign bus.hreset     = h_tc;
    assign bus.vreset     = v_tc;
    assign bus.hblank     = hblank_q;
    assign bus.vblank     = vblank_q;
    assign bus.hsync_n    = hsync_n_q;
    assign bus.vsync_n    = vsync_n_q;
    assign bus.line_tick  = line_tick_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_pong_sync_timer.sv
// Bench for pong_sync_timer: default and scaled-down timings checked every cycle
// against a model that derives position from the number of pixel enables seen.
module tb_pong_sync_timer;
    import pong_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_sync_timer_if bus_a ();
    pong_sync_timer_if bus_b ();

    pong_sync_timer u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    pong_sync_timer #(
        .H_TOTAL(16), .V_TOTAL(4), .H_BLANK_END(6), .HSYNC_START(2), .HSYNC_END(4),
        .V_BLANK_END(2), .VSYNC_START(1), .VSYNC_END(2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    longint      n        = 0;   // pixel enables since reset released
    bit          last_ce  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string nm, input longint H, V, HBE, HS, HE, VBE, VS, VE,
                           input logic [8:0] hc, vc,
                           input logic hr, vr, hb, vb, hs, vs, lt, ft);
        longint h, v;
        h = n % H;
        v = (n / H) % V;
        chk({nm, ".hcnt"},       32'(hc), 32'(h));
        chk({nm, ".vcnt"},       32'(vc), 32'(v));
        chk({nm, ".hreset"},     32'(hr), 32'(h == H - 1));
        chk({nm, ".vreset"},     32'(vr), 32'(v == V - 1));
        chk({nm, ".hblank"},     32'(hb), 32'(h < HBE));
        chk({nm, ".vblank"},     32'(vb), 32'(v < VBE));
        chk({nm, ".hsync_n"},    32'(hs), 32'(!(h >= HS && h < HE)));
        chk({nm, ".vsync_n"},    32'(vs), 32'(!(v >= VS && v < VE)));
        chk({nm, ".line_tick"},  32'(lt), 32'(last_ce && n > 0 && h == 0));
        chk({nm, ".frame_tick"}, 32'(ft), 32'(last_ce && n > 0 && (n % (H * V)) == 0));
    endtask

    task automatic check_all();
        chk_dut("dflt", 455, 262, 80, 32, 64, 16, 4, 8,
                bus_a.hcnt, bus_a.vcnt, bus_a.hreset, bus_a.vreset, bus_a.hblank,
                bus_a.vblank, bus_a.hsync_n, bus_a.vsync_n, bus_a.line_tick, bus_a.frame_tick);
        chk_dut("small", 16, 4, 6, 2, 4, 2, 1, 2,
                bus_b.hcnt, bus_b.vcnt, bus_b.hreset, bus_b.vreset, bus_b.hblank,
                bus_b.vblank, bus_b.hsync_n, bus_b.vsync_n, bus_b.line_tick, bus_b.frame_tick);
    endtask

    // One clock: present ce, advance the model at the edge, sample at the falling edge.
    task automatic step(input logic ce_v);
        bus_a.ce = ce_v;
        bus_b.ce = ce_v;
        @(posedge clk);
        if (rst_n && ce_v) begin
            n++;
            last_ce = 1'b1;
        end else begin
            last_ce = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    int hs_low, hb_high, hr_cnt, lt_cnt, vs_low, vb_high, vr_cnt, ce_cnt;

    initial begin
        bus_a.ce = 1'b0;
        bus_b.ce = 1'b0;

        // Reset held with ce toggling
        for (int i = 0; i < 8; i++) step(logic'(i % 2));

        // Release; first ce gives hcnt=1
        rst_n = 1'b1;
        step(1'b1);
        chk("first_ce_hcnt", 32'(bus_a.hcnt), 32'd1);

        // Continuous ce over the first 20 lines (n runs 2..9101)
        hs_low = 0; hb_high = 0; hr_cnt = 0; lt_cnt = 0; vs_low = 0; vb_high = 0; vr_cnt = 0;
        for (int i = 0; i < 9100; i++) begin
            step(1'b1);
            if (!bus_a.hsync_n) hs_low++;
            if (bus_a.hblank)   hb_high++;
            if (bus_a.hreset)   hr_cnt++;
            if (bus_a.line_tick) lt_cnt++;
            if (!bus_a.vsync_n) vs_low++;
            if (bus_a.vblank)   vb_high++;
            if (bus_a.vreset)   vr_cnt++;
        end
        chk("hsync_low_count",  32'(hs_low),  32'd640);
        chk("hblank_count",     32'(hb_high), 32'd1600);
        chk("hreset_count",     32'(hr_cnt),  32'd20);
        chk("line_tick_count",  32'(lt_cnt),  32'd20);
        chk("vsync_low_count",  32'(vs_low),  32'd1820);
        chk("vblank_count",     32'(vb_high), 32'(16 * 455 - 2));
        chk("vreset_count",     32'(vr_cnt),  32'd0);

        // ce one clock in four, then random enables
        for (int i = 0; i < 800; i++) step(logic'((i % 4) == 0));
        for (int i = 0; i < 3000; i++) step(logic'($urandom_range(3) == 0));

        // Advance to hcnt=200, vcnt=100 on the default timing
        while (n < 100 * 455 + 200) step(1'b1);
        chk("mid_hcnt", 32'(bus_a.hcnt), 32'd200);
        chk("mid_vcnt", 32'(bus_a.vcnt), 32'd100);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        n = 0;
        last_ce = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;

        // Frame period on the scaled timing after release
        ce_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1);
            ce_cnt++;
            if (bus_b.frame_tick) break;
        end
        chk("small_frame_period", 32'(ce_cnt), 32'd64);
        chk("small_frame_line_tick", 32'(bus_b.line_tick), 32'd1);

        // A few more scaled frames with random enables
        for (int i = 0; i < 1500; i++) step(logic'($urandom_range(1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
